// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C power-up init sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT,
        GAP,
        NEXT,
        DELAY,
        DONE_ST
    } state_t;

    localparam logic [23:0] END_MARK  = 24'hFFFFFF;
    localparam logic [7:0]  DELAY_TAG = 8'hFE;

    // Timer must hold the longest of the transfer budget, the bus gap and the largest delay entry.
    function automatic int timer_width(input int xfer, input int gap, input int unit);
        int m;
        m = xfer;
        if (gap > m) m = gap;
        if (unit * 65535 > m) m = unit * 65535;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter; LOAD wins over counting, and the count rests at zero.
module i2c_seq_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         LOAD,
    input  logic [W-1:0] VALUE,
    output logic         ZERO
);

    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (LOAD) begin
            count <= VALUE;
        end else if (count != '0) begin
            count <= count - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign ZERO = (count == '0);

endmodule

// File: rtl/i2c_init_seq.sv
// Walks a {slave_addr,reg,data} table and pulses the I2C write transmitter once per entry.
// Optional feature: define I2C_SEQ_DELAY_EN to treat entries tagged 8'hFE as timed delays.
module i2c_init_seq
    import i2c_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 8,
    parameter int XFER_CYCLES = 80,
    parameter int GAP_CYCLES  = 16,
    parameter int DELAY_UNIT  = 1000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic [IDX_W-1:0] ROM_ADDR,
    input  logic [23:0]      ROM_DATA,
    output logic [23:0]      TX_DATA,
    output logic             TX_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic [IDX_W-1:0] INDEX,
    output state_t           STATE
);

    localparam int TW = timer_width(XFER_CYCLES, GAP_CYCLES, DELAY_UNIT);
    localparam logic [TW-1:0]  XFER_LOAD = TW'(XFER_CYCLES - 1);
    localparam logic [TW-1:0]  GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [IDX_W:0] IDX_ONE   = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] IDX_LAST  = (IDX_W+1)'(NUM_ENTRIES);

    state_t          state;
    state_t          state_nx;
    logic            timer_load;
    logic [TW-1:0]   timer_value;
    logic            timer_zero;
    logic [IDX_W:0]  index_inc;

    assign index_inc = {1'b0, INDEX} + IDX_ONE;
    assign STATE     = state;

`ifdef I2C_SEQ_DELAY_EN
    logic [TW-1:0] delay_cycles;
    logic [TW-1:0] delay_load;

    // A zero-length delay still spends one cycle in DELAY.
    assign delay_cycles = TW'(ROM_DATA[15:0]) * TW'(DELAY_UNIT);
    assign delay_load   = (delay_cycles == '0) ? '0 : delay_cycles - TW'(1);
`endif

    i2c_seq_timer #(.W(TW)) u_timer (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LOAD  (timer_load),
        .VALUE (timer_value),
        .ZERO  (timer_zero)
    );

    always_comb begin
        state_nx    = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE:    if (START) state_nx = FETCH;
            FETCH:   state_nx = LATCH;
            LATCH: begin
                if (ROM_DATA == END_MARK) begin
                    state_nx = DONE_ST;
`ifdef I2C_SEQ_DELAY_EN
                end else if (ROM_DATA[23:16] == DELAY_TAG) begin
                    state_nx    = DELAY;
                    timer_load  = 1'b1;
                    timer_value = delay_load;
`endif
                end else begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx    = WAIT;
                timer_load  = 1'b1;
                timer_value = XFER_LOAD;
            end
            WAIT: begin
                if (timer_zero) begin
                    if (GAP_CYCLES == 0) begin
                        state_nx = NEXT;
                    end else begin
                        state_nx    = GAP;
                        timer_load  = 1'b1;
                        timer_value = GAP_LOAD;
                    end
                end
            end
            GAP:     if (timer_zero) state_nx = NEXT;
`ifdef I2C_SEQ_DELAY_EN
            DELAY:   if (timer_zero) state_nx = NEXT;
`endif
            NEXT:    state_nx = (index_inc == IDX_LAST) ? DONE_ST : FETCH;
            DONE_ST: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // TX_EN is registered from the next state so it is high for exactly the ISSUE cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ROM_ADDR <= '0;
            TX_DATA  <= '0;
            TX_EN    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            INDEX    <= '0;
        end else begin
            state <= state_nx;
            TX_EN <= (state_nx == ISSUE);
            case (state)
                IDLE: begin
                    if (START) begin
                        ROM_ADDR <= '0;
                        INDEX    <= '0;
                        DONE     <= 1'b0;
                        BUSY     <= 1'b1;
                    end
                end
                LATCH: begin
                    if (state_nx == ISSUE) TX_DATA <= ROM_DATA;
                end
                NEXT: begin
                    INDEX <= index_inc[IDX_W-1:0];
                    if (state_nx == FETCH) ROM_ADDR <= index_inc[IDX_W-1:0];
                end
                DONE_ST: begin
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Table-driven bench for i2c_init_seq: a timing model fills a scoreboard of expected TX pulses per run.
module tb_i2c_init_seq;
    import i2c_pkg::*;

    localparam int NUM  = 3;
    localparam int XFER = 80;
    localparam int GAP  = 16;
    localparam int UNIT = 10;

    typedef struct {
        logic [23:0] w0;
        logic [23:0] w1;
        logic [23:0] w2;
        int          restart_at;
        string       name;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  ROM_ADDR;
    logic [23:0] ROM_DATA;
    logic [23:0] TX_DATA;
    logic        TX_EN;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  INDEX;
    state_t      STATE;

    logic [23:0] rom [0:3];
    vec_t        vecs [7];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          max_addr = 0;
    logic [23:0] exp_q [$];
    int          exp_t_q [$];
    logic [23:0] mon_d;
    int          mon_t;

    i2c_init_seq #(
        .NUM_ENTRIES (NUM),
        .IDX_W       (8),
        .XFER_CYCLES (XFER),
        .GAP_CYCLES  (GAP),
        .DELAY_UNIT  (UNIT)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA),
        .TX_DATA  (TX_DATA),
        .TX_EN    (TX_EN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .INDEX    (INDEX),
        .STATE    (STATE)
    );

    // clock / synchronous table ROM (data one cycle after address)
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        ROM_DATA <= rom[ROM_ADDR[1:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: every TX_EN pulse must match the next expected word and its cycle offset
    always @(negedge CLK) begin
        if (int'(ROM_ADDR) > max_addr) max_addr = int'(ROM_ADDR);
        if (TX_EN === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_en_unexpected: pulse with TX_DATA=%h at offset %0d, expected none",
                         TX_DATA, cyc - start_cyc);
            end else begin
                mon_d = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                if (TX_DATA !== mon_d) begin
                    failures++;
                    $display("FAIL tx_data: got %h, expected %h", TX_DATA, mon_d);
                end
                check("tx_offset", cyc - start_cyc, mon_t);
            end
        end
    end

    // Offsets are counted in cycles after the edge that sampled START (FETCH = 0).
    task automatic build_expect(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                                output int exp_idx, output int exp_done);
        logic [23:0] t [3];
        int c;
        int nxt;
        int cost;
        t[0] = w0;
        t[1] = w1;
        t[2] = w2;
        c = 0;
        nxt = 0;
        exp_idx = 0;
        exp_done = 0;
        for (int i = 0; i < NUM; i++) begin
            if (t[i] == 24'hFFFFFF) begin
                exp_done = c + 3;
                break;
            end
`ifdef I2C_SEQ_DELAY_EN
            if (t[i][23:16] == 8'hFE) begin
                cost = int'(t[i][15:0]) * UNIT;
                if (cost == 0) cost = 1;
                nxt = c + 2 + cost;
            end else
`endif
            begin
                exp_q.push_back(t[i]);
                exp_t_q.push_back(c + 2);
                nxt = c + 2 + XFER + GAP + 1;
            end
            exp_idx++;
            if (exp_idx == NUM) begin
                exp_done = nxt + 2;
                break;
            end
            c = nxt + 1;
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_vec(input int v);
        int  exp_idx;
        int  exp_done;
        bit  got;
        rom[0] = vecs[v].w0;
        rom[1] = vecs[v].w1;
        rom[2] = vecs[v].w2;
        build_expect(vecs[v].w0, vecs[v].w1, vecs[v].w2, exp_idx, exp_done);
        pulse_start();
        check({vecs[v].name, "_busy_start"}, BUSY, 1);
        check({vecs[v].name, "_done_clr"}, DONE, 0);
        check({vecs[v].name, "_addr_start"}, ROM_ADDR, 0);
        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge CLK);
            START = (vecs[v].restart_at != 0) && (cyc - start_cyc == vecs[v].restart_at - 1);
            if (DONE === 1'b1) got = 1;
        end
        START = 1'b0;
        check({vecs[v].name, "_done_seen"}, got, 1);
        check({vecs[v].name, "_done_offset"}, cyc - start_cyc, exp_done);
        check({vecs[v].name, "_index"}, INDEX, exp_idx);
        check({vecs[v].name, "_busy_end"}, BUSY, 0);
        check({vecs[v].name, "_pulses_missing"}, exp_q.size(), 0);
        exp_q.delete();
        exp_t_q.delete();
        repeat (3) @(negedge CLK);
        check({vecs[v].name, "_done_sticky"}, DONE, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_addr"}, ROM_ADDR, 0);
        check({tag, "_tx_data"}, TX_DATA, 0);
        check({tag, "_tx_en"}, TX_EN, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_index"}, INDEX, 0);
        check({tag, "_state"}, 32'(STATE), 32'(IDLE));
    endtask

    initial begin
        bit seen_tx;
        bit seen_busy;
        bit seen_done;
        bit seen_addr;
        bit in_wait;

        for (int i = 0; i < 4; i++) rom[i] = 24'h0;
        vecs[0] = '{24'h421001, 24'h421102, 24'h421203, 0, "basic"};
        vecs[1] = '{24'h421001, 24'hFFFFFF, 24'h421203, 0, "early_end"};
        vecs[2] = '{24'h421001, 24'h421102, 24'h421203, 50, "restart"};
        vecs[3] = '{24'hFE0005, 24'h421001, 24'hFFFFFF, 0, "delay"};
        vecs[4] = '{24'hFFFFFF, 24'h421001, 24'h421102, 0, "empty"};
        vecs[5] = '{24'hFE0000, 24'h3C0A55, 24'hFFFFFF, 0, "delay_zero"};
        vecs[6] = '{24'($urandom_range(0, 24'hFDFFFF)), 24'($urandom_range(0, 24'hFDFFFF)),
                    24'($urandom_range(0, 24'hFDFFFF)), 0, "random"};

        // reset and idle with no START
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST_N = 1'b1;
        seen_tx = 0;
        seen_busy = 0;
        seen_done = 0;
        seen_addr = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (TX_EN !== 1'b0) seen_tx = 1;
            if (BUSY !== 1'b0) seen_busy = 1;
            if (DONE !== 1'b0) seen_done = 1;
            if (ROM_ADDR !== 8'h0) seen_addr = 1;
        end
        check("idle_tx_en", seen_tx, 0);
        check("idle_busy", seen_busy, 0);
        check("idle_done", seen_done, 0);
        check("idle_rom_addr", seen_addr, 0);

        for (int v = 0; v < 7; v++) run_vec(v);

        // reset during WAIT of entry 1, then a clean restart
        rom[0] = 24'h421001;
        rom[1] = 24'h421102;
        rom[2] = 24'h421203;
        exp_q.push_back(24'h421001);
        exp_t_q.push_back(2);
        exp_q.push_back(24'h421102);
        exp_t_q.push_back(102);
        pulse_start();
        in_wait = 0;
        for (int k = 0; k < 300 && !in_wait; k++) begin
            @(negedge CLK);
            if (cyc - start_cyc == 112) in_wait = 1;
        end
        check("abort_reached", in_wait, 1);
        check("abort_state_wait", 32'(STATE), 32'(WAIT));
        check("abort_index", INDEX, 1);
        check("abort_pending", exp_q.size(), 0);
        RST_N = 1'b0;
        @(negedge CLK);
        check_reset_outputs("abort");
        exp_q.delete();
        exp_t_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        run_vec(0);

        check("rom_addr_range", max_addr <= NUM - 1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
